// File: rtl/v_ram_arbiter_if.sv
// Two-lane request/response bundle between online-multiplier lanes and v_ram_arbiter.
// The master side is the requesting lane logic; the slave side is the arbiter.
interface v_ram_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 7
);
    logic                  r0_valid;
    logic                  r0_we;
    logic [ADDR_WIDTH-1:0] r0_addr;
    logic [DATA_WIDTH-1:0] r0_wdata;
    logic                  r0_lock;
    logic                  r0_ready;
    logic                  r0_rvalid;
    logic [DATA_WIDTH-1:0] r0_rdata;

    logic                  r1_valid;
    logic                  r1_we;
    logic [ADDR_WIDTH-1:0] r1_addr;
    logic [DATA_WIDTH-1:0] r1_wdata;
    logic                  r1_lock;
    logic                  r1_ready;
    logic                  r1_rvalid;
    logic [DATA_WIDTH-1:0] r1_rdata;

    modport master (
        output r0_valid, r0_we, r0_addr, r0_wdata, r0_lock,
        output r1_valid, r1_we, r1_addr, r1_wdata, r1_lock,
        input  r0_ready, r0_rvalid, r0_rdata,
        input  r1_ready, r1_rvalid, r1_rdata
    );

    modport slave (
        input  r0_valid, r0_we, r0_addr, r0_wdata, r0_lock,
        input  r1_valid, r1_we, r1_addr, r1_wdata, r1_lock,
        output r0_ready, r0_rvalid, r0_rdata,
        output r1_ready, r1_rvalid, r1_rdata
    );
endinterface

// File: rtl/v_ram_arbiter.sv
// Clear sequencer plus two-lane round-robin arbiter for the v-value residual RAM.
// Define V_ARB_LOCK_EN to let a lane hold priority across consecutive requests via rN_lock.
module v_ram_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    output logic                  busy,
    v_ram_arbiter_if.slave        req,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_write_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic [ADDR_WIDTH-1:0] ram_read_addr,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_cnt, w_cnt_nxt;
    logic                  r_rr, w_rr_nxt;
    logic [1:0]            r_rvalid, w_rvalid_nxt;
    logic [ADDR_WIDTH-1:0] r_rd_addr, w_rd_addr_nxt;
    logic [1:0]            w_ready;

    logic [1:0]            w_valid;
    logic [1:0]            w_we;
    logic [ADDR_WIDTH-1:0] w_addr  [2];
    logic [DATA_WIDTH-1:0] w_wdata [2];
    logic                  w_prio;
    logic                  w_lane;

    assign w_valid    = {req.r1_valid, req.r0_valid};
    assign w_we       = {req.r1_we, req.r0_we};
    assign w_addr[0]  = req.r0_addr;
    assign w_addr[1]  = req.r1_addr;
    assign w_wdata[0] = req.r0_wdata;
    assign w_wdata[1] = req.r1_wdata;

`ifdef V_ARB_LOCK_EN
    logic [1:0] w_lock;
    logic       r_lock_act, w_lock_act_nxt;
    logic       r_lock_lane, w_lock_lane_nxt;

    assign w_lock = {req.r1_lock, req.r0_lock};
    assign w_prio = r_lock_act ? r_lock_lane : r_rr;
`else
    logic w_unused_lock;

    assign w_unused_lock = req.r0_lock ^ req.r1_lock;
    assign w_prio        = r_rr;
`endif

    // With both lanes asking the priority lane wins; otherwise whichever lane is valid.
    assign w_lane = (&w_valid) ? w_prio : w_valid[1];

    // NOTE: every output and next-state value gets a default before the case so no latch is inferred.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_rr_nxt       = r_rr;
        w_rvalid_nxt   = 2'b00;
        w_rd_addr_nxt  = r_rd_addr;
        w_ready        = 2'b00;
        busy           = 1'b0;
        ram_we         = 1'b0;
        ram_write_addr = w_addr[w_lane];
        ram_data       = w_wdata[w_lane];
        ram_read_addr  = r_rd_addr;
`ifdef V_ARB_LOCK_EN
        w_lock_act_nxt  = 1'b0;
        w_lock_lane_nxt = r_lock_lane;
`endif

        case (r_state)
            ST_CLEAR: begin
                busy           = 1'b1;
                ram_we         = 1'b1;
                ram_write_addr = r_cnt;
                ram_data       = '0;
                if (clr) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == '1) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            ST_RUN: begin
                if (clr) begin
                    w_state_nxt = ST_CLEAR;
                    w_cnt_nxt   = '0;
                end else if (|w_valid) begin
                    w_ready[w_lane] = 1'b1;
                    if (w_we[w_lane]) begin
                        ram_we = 1'b1;
                    end else begin
                        ram_read_addr        = w_addr[w_lane];
                        w_rd_addr_nxt        = w_addr[w_lane];
                        w_rvalid_nxt[w_lane] = 1'b1;
                    end
`ifdef V_ARB_LOCK_EN
                    if (w_lock[w_lane]) begin
                        w_lock_act_nxt  = 1'b1;
                        w_lock_lane_nxt = w_lane;
                    end else begin
                        w_rr_nxt = ~w_lane;
                    end
`else
                    w_rr_nxt = ~w_lane;
`endif
                end
            end

            default: w_state_nxt = ST_CLEAR;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_CLEAR;
            r_cnt     <= '0;
            r_rr      <= 1'b0;
            r_rvalid  <= 2'b00;
            r_rd_addr <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rr      <= w_rr_nxt;
            r_rvalid  <= w_rvalid_nxt;
            r_rd_addr <= w_rd_addr_nxt;
        end
    end

`ifdef V_ARB_LOCK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_act  <= 1'b0;
            r_lock_lane <= 1'b0;
        end else begin
            r_lock_act  <= w_lock_act_nxt;
            r_lock_lane <= w_lock_lane_nxt;
        end
    end
`endif

    assign req.r0_ready  = w_ready[0];
    assign req.r1_ready  = w_ready[1];
    assign req.r0_rvalid = r_rvalid[0];
    assign req.r1_rvalid = r_rvalid[1];
    assign req.r0_rdata  = ram_q;
    assign req.r1_rdata  = ram_q;

endmodule
